rf_write_arbiter: RTL and testbench

// - Shares the single scalar register-file write port (ra3/wd3/we3) between the

---
 rtl/rf_write_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port arbiter between W stage and aux unit
//
// Shares the single register-file write port between the pipeline W stage and
// a multi-cycle auxiliary unit (divider / memory fill). The W stage normally
// wins. Aux results that cannot go straight to the register file wait in a
// small FIFO. The FIFO drains on idle W cycles, or by stalling W when the FIFO
// is full or (optionally) has waited too long.
//
// Optional feature macro: RF_ARB_STARVE_GUARD_EN
//   defined   : a wait counter forces a drain after MAX_WAIT cycles of waiting
//   undefined : a drain is forced only when the FIFO is full; MAX_WAIT has no effect
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   synchronous active-low reset
//   wb_we_i       in   W-stage write request
//   wb_wa_i       in   W-stage destination register
//   wb_wd_i       in   W-stage write data
//   aux_valid_i   in   aux result valid
//   aux_ready_o   out  aux result accepted this cycle (when valid)
//   aux_wa_i      in   aux destination register
//   aux_wd_i      in   aux write data
//   stall_w_o     out  hold W stage; wb_* ignored this cycle, re-presented next
//   rf_we_o       out  register-file write enable
//   rf_wa_o       out  register-file write address
//   rf_wd_o       out  register-file write data
//   pending_o     out  bit n set while any FIFO entry targets register n
//   fifo_count_o  out  current FIFO occupancy

module rf_write_arbiter #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_wa_i,
  input  logic [WIDTH-1:0]           wb_wd_i,
  input  logic                       aux_valid_i,
  output logic                       aux_ready_o,
  input  logic [4:0]                 aux_wa_i,
  input  logic [WIDTH-1:0]           aux_wd_i,
  output logic                       stall_w_o,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_wa_o,
  output logic [WIDTH-1:0]           rf_wd_o,
  output logic [31:0]                pending_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage; per-slot valid bits let pending_o be rebuilt from contents.
  logic [4:0]       wa_mem [DEPTH];
  logic [WIDTH-1:0] wd_mem [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [31:0]      pending_q;
  logic [31:0]      pending_d;

  logic has_entry;
  logic full;
  logic starve;
  logic force_drain;
  logic deq;
  logic bypass;
  logic enq;

  assign has_entry = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_q;

  assign starve = has_entry && (wait_q == WW'(MAX_WAIT));

  // Counts cycles the head entry has been left waiting; any dequeue or an
  // empty FIFO restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q <= '0;
    end else if (deq || !has_entry) begin
      wait_q <= '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  // MAX_WAIT has no effect in this build; entries may wait indefinitely.
  assign starve = 1'b0 & (MAX_WAIT > 0);
`endif

  // Every combinational output is qualified by reset so the port stays quiet
  // while reset is held, even before the first clock edge clears state.
  assign force_drain = reset && (full || starve);
  assign deq         = force_drain || (reset && !wb_we_i && has_entry);
  assign aux_ready_o = reset && (!full || deq);
  // Bypass only when nothing is queued, so it can never overtake FIFO entries.
  assign bypass      = reset && !wb_we_i && !has_entry && aux_valid_i;
  assign enq         = aux_valid_i && aux_ready_o && !bypass;

  assign stall_w_o    = force_drain;
  assign pending_o    = pending_q;
  assign fifo_count_o = count_q;

  always_comb begin
    rf_we_o = 1'b0;
    rf_wa_o = '0;
    rf_wd_o = '0;
    if (force_drain) begin
      rf_we_o = 1'b1;
      rf_wa_o = wa_mem[head_q];
      rf_wd_o = wd_mem[head_q];
    end else if (reset && wb_we_i) begin
      rf_we_o = 1'b1;
      rf_wa_o = wb_wa_i;
      rf_wd_o = wb_wd_i;
    end else if (deq) begin
      rf_we_o = 1'b1;
      rf_wa_o = wa_mem[head_q];
      rf_wd_o = wd_mem[head_q];
    end else if (bypass) begin
      rf_we_o = 1'b1;
      rf_wa_o = aux_wa_i;
      rf_wd_o = aux_wd_i;
    end
  end

  // Next-cycle contents. When full, head and tail alias: the clear for the
  // dequeue is applied before the set for the enqueue so the slot stays valid.
  always_comb begin
    logic [4:0] wa_n;
    vld_d     = vld_q;
    pending_d = '0;
    if (deq) vld_d[head_q] = 1'b0;
    if (enq) vld_d[tail_q] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wa_n = (enq && (tail_q == PW'(i))) ? aux_wa_i : wa_mem[i];
      if (vld_d[i]) pending_d[wa_n] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      pending_q <= '0;
    end else begin
      if (enq) begin
        wa_mem[tail_q] <= aux_wa_i;
        wd_mem[tail_q] <= aux_wd_i;
        tail_q         <= tail_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      vld_q     <= vld_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed table-driven bench for rf_write_arbiter

module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [63:0] wb_wd;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wa;
  logic [63:0] aux_wd;
  logic        stall_w;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [31:0] pending;
  logic [2:0]  fcount;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.WIDTH(64), .DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_we_i(wb_we), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd),
    .aux_valid_i(aux_valid), .aux_ready_o(aux_ready),
    .aux_wa_i(aux_wa), .aux_wd_i(aux_wd),
    .stall_w_o(stall_w), .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
    .pending_o(pending), .fifo_count_o(fcount)
  );

  typedef struct {
    logic        rst;
    logic        wwe;
    logic [4:0]  wwa;
    logic [63:0] wwd;
    logic        av;
    logic [4:0]  awa;
    logic [63:0] awd;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic rst, input logic wwe, input logic [4:0] wwa,
                              input logic [63:0] wwd, input logic av, input logic [4:0] awa,
                              input logic [63:0] awd, input logic e_stall, input logic e_we,
                              input logic [4:0] e_wa, input logic [63:0] e_wd,
                              input logic e_rdy, input logic [2:0] e_cnt,
                              input logic [31:0] e_pend);
    vec_t v;
    v.rst = rst; v.wwe = wwe; v.wwa = wwa; v.wwd = wwd;
    v.av = av; v.awa = awa; v.awd = awd;
    v.e_stall = e_stall; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                       input logic a, input logic [4:0] awa_v, input logic [63:0] awd_v);
    wb_we = w; wb_wa = wa; wb_wd = wd;
    aux_valid = a; aux_wa = awa_v; aux_wd = awd_v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int got;
    logic hold_chk;
    logic [107:0] act;
    logic [107:0] exp;

    //          rst wwe wwa wwd     av awa awd      stl we wa wd       rdy cnt pend
    vt[0]  = mk(0, 0,  0, 0,       0, 0,  0,       0, 0, 0, 0,       0, 0, 32'h0);
    vt[1]  = mk(1, 0,  0, 0,       1, 5,  'hAA,    0, 1, 5, 'hAA,    1, 0, 32'h0);
    vt[2]  = mk(1, 0,  0, 0,       0, 0,  0,       0, 0, 0, 0,       1, 0, 32'h0);
    vt[3]  = mk(1, 1, 10, 'h100,   1, 1,  'h11,    0, 1, 10, 'h100,  1, 0, 32'h0);
    vt[4]  = mk(1, 1, 11, 'h101,   1, 2,  'h12,    0, 1, 11, 'h101,  1, 1, 32'h2);
    vt[5]  = mk(1, 1, 12, 'h102,   1, 3,  'h13,    0, 1, 12, 'h102,  1, 2, 32'h6);
    vt[6]  = mk(1, 1, 13, 'h103,   1, 4,  'h14,    0, 1, 13, 'h103,  1, 3, 32'hE);
    vt[7]  = mk(1, 1, 14, 'h104,   1, 5,  'h15,    1, 1, 1, 'h11,    1, 4, 32'h1E);
    vt[8]  = mk(1, 1, 14, 'h104,   0, 0,  0,       1, 1, 2, 'h12,    1, 4, 32'h3C);
    vt[9]  = mk(1, 1, 14, 'h104,   0, 0,  0,       0, 1, 14, 'h104,  1, 3, 32'h38);
    vt[10] = mk(1, 0,  0, 0,       0, 0,  0,       0, 1, 3, 'h13,    1, 3, 32'h38);
    vt[11] = mk(1, 0,  0, 0,       1, 7,  'h17,    0, 1, 4, 'h14,    1, 2, 32'h30);
    vt[12] = mk(1, 0,  0, 0,       0, 0,  0,       0, 1, 5, 'h15,    1, 2, 32'hA0);
    vt[13] = mk(1, 0,  0, 0,       0, 0,  0,       0, 1, 7, 'h17,    1, 1, 32'h80);
    vt[14] = mk(1, 0,  0, 0,       0, 0,  0,       0, 0, 0, 0,       1, 0, 32'h0);
    vt[15] = mk(1, 1, 20, 'h200,   1, 8,  'h18,    0, 1, 20, 'h200,  1, 0, 32'h0);
    vt[16] = mk(1, 1, 21, 'h201,   1, 9,  'h19,    0, 1, 21, 'h201,  1, 1, 32'h100);
    vt[17] = mk(1, 1, 22, 'h202,   1, 10, 'h1A,    0, 1, 22, 'h202,  1, 2, 32'h300);
    vt[18] = mk(0, 1, 23, 'h203,   1, 11, 'h1B,    0, 0, 0, 0,       0, 3, 32'h700);
    vt[19] = mk(1, 0,  0, 0,       0, 0,  0,       0, 0, 0, 0,       1, 0, 32'h0);
    vt[20] = mk(1, 0,  0, 0,       0, 0,  0,       0, 0, 0, 0,       1, 0, 32'h0);

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      reset = vt[i].rst;
      drive(vt[i].wwe, vt[i].wwa, vt[i].wwd, vt[i].av, vt[i].awa, vt[i].awd);
      @(negedge clk);
      // Address/data only matter when a write is expected.
      act = {stall_w, rf_we, vt[i].e_we ? rf_wa : 5'd0, vt[i].e_we ? rf_wd : 64'd0,
             aux_ready, fcount, pending};
      exp = {vt[i].e_stall, vt[i].e_we, vt[i].e_wa, vt[i].e_wd,
             vt[i].e_rdy, vt[i].e_cnt, vt[i].e_pend};
      chk($sformatf("row%0d", i), 128'(act), 128'(exp));
      next_cycle();
    end

    // Continuous W plus 10 aux results: fills, force-drains at full with
    // simultaneous enqueue, wraps pointers, then drains on idle W.
    sent = 0;
    got = 0;
    hold_chk = 1'b0;
    for (int c = 0; c < 200 && got < 10; c++) begin
      drive(sent < 10, 20, 0, sent < 10, 5'(sent + 1), 64'h1000 + 64'(sent));
      @(negedge clk);
      if (hold_chk) chk("count_hold_at_full", 128'(fcount), 128'(4));
      hold_chk = 1'b0;
      if (aux_valid && fcount == 3'd4) chk("ready_at_full", 128'(aux_ready), 128'(1));
      if (aux_valid && aux_ready) begin
        sent++;
        if (fcount == 3'd4 && sent < 10) hold_chk = 1'b1;
      end
      if (rf_we && rf_wd[12]) begin
        chk($sformatf("wrap_order%0d", got), 128'({rf_wa, rf_wd}),
            128'({5'(got + 1), 64'h1000 + 64'(got)}));
        got++;
      end
      next_cycle();
    end
    chk("wrap_total", 128'(got), 128'(10));
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_empty", 128'({fcount, pending}), 128'(0));
    next_cycle();

    // One aux entry parked under continuous W writes.
    drive(1, 20, 0, 1, 6, 64'h66);
    next_cycle();
    drive(1, 20, 0, 0, 0, 0);
`ifdef RF_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("starve_stall_c%0d", k), 128'(stall_w), 128'(k == 9));
      if (k == 9) chk("starve_write", 128'({rf_we, rf_wa, rf_wd}), 128'({1'b1, 5'd6, 64'h66}));
      next_cycle();
    end
    @(negedge clk);
    chk("starve_empty", 128'(fcount), 128'(0));
    next_cycle();
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (stall_w) chk($sformatf("no_stall_c%0d", k), 128'(stall_w), 128'(0));
      next_cycle();
    end
    @(negedge clk);
    chk("parked_stall", 128'(stall_w), 128'(0));
    chk("parked_count", 128'(fcount), 128'(1));
    chk("parked_pending", 128'(pending), 128'(32'h40));
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("parked_drain", 128'({rf_we, rf_wa, rf_wd}), 128'({1'b1, 5'd6, 64'h66}));
    next_cycle();
    @(negedge clk);
    chk("parked_empty", 128'({fcount, pending}), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
